hamming15_tx_ctrl: RTL and testbench
====================================

# hamming15_tx_ctrl

Transmit-side controller that shares one Hamming(15,11) encoder instance between two data requesters and serializes the resulting 16-bit codewords onto a one-bit channel.
- Arbitrates requesters round-robin.
- Sequences the registered encoder: applies the data, waits out its latency, then captures its output.
- Inserts the overall (even) parity bit into codeword bit 0.
- Shifts the 16 bits out MSB first under a valid/ready handshake.
- Sits between the packet sources and the channel modulator.

## Interface
- GAP, 1, idle cycles inserted after the last bit of a frame before the next grant (0..15).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; also drives the encoder's reset input.
- req0  in  1  requester 0 has a word; hold high with stable data until ack0.
- data0  in  11  requester 0 data word.
- ack0  out  1  one-cycle pulse: data0 accepted.
- req1  in  1  requester 1 has a word; hold high with stable data until ack1.
- data1  in  11  requester 1 data word.
- ack1  out  1  one-cycle pulse: data1 accepted.
- enc_in  out  11  registered data to the encoder input.
- enc_out  in  16  encoder codeword; bits 15:1 are used, bit 0 is ignored.
- enc_ready  in  1  encoder output valid.
- tx_bit  out  1  serial codeword bit.
- tx_valid  out  1  tx_bit is valid.
- tx_start  out  1  high with the first bit (bit 15) of each frame.
- tx_ready  in  1  channel accepts tx_bit this cycle.
- tx_src  out  1  requester index of the frame being sent.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ENC, CAPT, SHIFT, GAP.
- IDLE:
  - If any req is high, grant by round-robin.
  - If both req are high, grant the requester not granted last.
  - The last-grant register resets to 1, so requester 0 wins the first tie.
  - On grant: enc_in <= data_k, tx_src <= k, ack_k pulses for one cycle, go to ENC.
- ENC: enc_in is held. One cycle for the encoder register to sample it. Go to CAPT.
- CAPT:
  - If enc_ready = 1: shift register <= {enc_out[15:1], ^enc_out[15:1]}, bit_cnt <= 15, go to SHIFT.
  - Otherwise stay in CAPT.
- SHIFT:
  - tx_valid = 1 and tx_bit = shift register bit 15.
  - tx_start = 1 while bit_cnt = 15 and that bit has not yet been transferred.
  - On tx_valid & tx_ready: shift left by one and decrement bit_cnt.
  - On the transfer with bit_cnt = 0: go to GAP, or to IDLE if GAP = 0.
  - With tx_ready low: hold tx_bit, the shift register and tx_start.
- GAP: count GAP cycles, then go to IDLE. req is ignored while in GAP.
- Requests arriving while busy are not acked. They are arbitrated at the next IDLE.
- A requester holding req high after its ack is treated as a new word.
- bit_cnt is 4 bits and never wraps: the SHIFT exit takes priority on the bit_cnt = 0 transfer.

## Timing
- Reset values:
  - Outputs: ack0 = ack1 = 0, tx_valid = 0, tx_start = 0, tx_bit = 0, busy = 0, tx_src = 0, enc_in = 0.
  - Internal: state IDLE, last-grant = 1.
- Reset asserted mid-frame: tx_valid drops immediately (asynchronously) and the frame is aborted. No partial resume after release.
- First cycle after reset release: IDLE, arbitration is active.
- Edge T samples req in IDLE. Then:
  - ack_k and busy are high in cycle T..T+1.
  - The encoder samples enc_in at T+1.
  - CAPT captures at T+2.
  - tx_valid, tx_start and bit 15 are visible after T+2.
  - Request-to-first-bit latency is 3 cycles when enc_ready = 1.
- With tx_ready tied high, a frame is 16 cycles. Request-to-request period is 3 + 16 + GAP cycles.
- ack is never asserted outside the IDLE-to-ENC transition. Only one ack is high at a time.

## Test plan
- Reset, then req0 = 1 with data0 = 11'h000:
  - ack0 pulses one cycle after the sampling edge.
  - 16 zero bits follow with tx_start on the first.
  - tx_src = 0 and busy falls GAP cycles after the last bit.
- req1 = 1 with data1 = 11'h7FF and tx_ready = 1: serial stream is 16'hFFFF MSB first, tx_src = 1.
- req0 with data0 = 11'h001: stream is 16'h000F (bits 3,2,1 from the encoder, parity = 1).
- req0 and req1 held high continuously, with data0 = 11'h001 and data1 = 11'h7FF:
  - Grants alternate 0,1,0,1 and ack0/ack1 never overlap.
  - Frames are separated by exactly GAP idle cycles plus 3.
- tx_ready toggled 1,0,0,1 during SHIFT: tx_bit and tx_start hold during the stalls, the frame still contains exactly 16 transfers, and the value matches the unstalled case.
- Two further error cases:
  - enc_ready held low for 4 cycles in CAPT: no tx_valid until enc_ready rises, then a normal frame.
  - reset pulsed after bit 8 of a frame: tx_valid = 0 immediately; after release, state is IDLE with no ack and no residual bits.

Source files
------------

// File: rtl/hamming15_tx_ctrl.sv
// hamming15_tx_ctrl: shares one registered Hamming(15,11) encoder between two round-robin requesters and serializes the 16-bit codeword MSB first
// Ports: clk/reset; req0/data0/ack0 and req1/data1/ack1 requester handshakes; enc_in/enc_out/enc_ready encoder link;
//        tx_bit/tx_valid/tx_start/tx_ready/tx_src serial channel; busy high outside IDLE. GAP = idle cycles after each frame.
module hamming15_tx_ctrl #(
  parameter int unsigned GAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [10:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [10:0] data1,
  output logic        ack1,
  output logic [10:0] enc_in,
  input  logic [15:0] enc_out,
  input  logic        enc_ready,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic        tx_src,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ENC, CAPT, SHIFT, HOLD} state_t;
  state_t      state;
  logic        last;
  logic [15:0] sr;
  logic [3:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic        grant1;
  // requester 1 wins alone, or on a tie when requester 0 was granted last
  assign grant1   = req1 && (!req0 || !last);
  assign tx_valid = state == SHIFT;
  // bit_cnt only leaves 15 on the first transfer, so this marks the untransferred first bit
  assign tx_start = tx_valid && bit_cnt == 4'd15;
  assign tx_bit   = sr[15];
  assign busy     = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      enc_in  <= '0;
      tx_src  <= 1'b0;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        IDLE: if (req0 || req1) begin
          enc_in <= grant1 ? data1 : data0;
          tx_src <= grant1;
          last   <= grant1;
          ack0   <= !grant1;
          ack1   <= grant1;
          state  <= ENC;
        end
        ENC: state <= CAPT;
        CAPT: if (enc_ready) begin
          // encoder bit 0 is unused; the overall even parity takes its place
          sr      <= {enc_out[15:1], ^enc_out[15:1]};
          bit_cnt <= 4'd15;
          state   <= SHIFT;
        end
        SHIFT: if (tx_ready) begin
          sr      <= {sr[14:0], 1'b0};
          bit_cnt <= (bit_cnt == 4'd0) ? 4'd0 : bit_cnt - 4'd1;
          if (bit_cnt == 4'd0) begin
            state   <= (GAP == 0) ? IDLE : HOLD;
            gap_cnt <= 4'(GAP - 1);
          end
        end
        HOLD: if (gap_cnt == 4'd0) state <= IDLE;
              else gap_cnt <= gap_cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hamming15_tx_ctrl.sv
// tb_hamming15_tx_ctrl: randomized self-checking bench with a behavioural encoder and frame reference model
module tb_hamming15_tx_ctrl;
  localparam int GAP = 2;
  logic clk = 0, reset = 1, req0 = 0, req1 = 0, enc_ready = 1, tx_ready = 1;
  logic [10:0] data0 = 0, data1 = 0, enc_in;
  logic [15:0] enc_out;
  logic ack0, ack1, tx_bit, tx_valid, tx_start, tx_src, busy;
  int pass_cnt = 0, total = 0;

  hamming15_tx_ctrl #(.GAP(GAP)) dut (
    .clk(clk), .reset(reset), .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1), .enc_in(enc_in), .enc_out(enc_out),
    .enc_ready(enc_ready), .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx_src(tx_src), .busy(busy)
  );

  always #5 clk = ~clk;

  // Positional Hamming code: codeword bit p is Hamming position p, parity at powers of two
  function automatic logic [14:0] ham(input logic [10:0] d);
    logic [15:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p < 16; p++) if ((p & (p - 1)) != 0) begin c[p] = d[k]; k++; end
    for (int q = 1; q < 16; q = q * 2)
      for (int p = 1; p < 16; p++) if ((p & q) != 0 && p != q) c[q] = c[q] ^ c[p];
    return c[15:1];
  endfunction

  function automatic logic [15:0] exp_frame(input logic [10:0] d);
    logic [14:0] h;
    h = ham(d);
    return {h, ^h};
  endfunction

  // Registered encoder; bit 0 carries junk the DUT must ignore
  logic [15:0] enc_q;
  always @(posedge clk or posedge reset)
    if (reset) enc_q <= '0;
    else enc_q <= {ham(enc_in), 1'($urandom)};
  assign enc_out = enc_q;

  // Monitor: collects frames, ack events and handshake-rule violations
  int cyc = 0, nb = 0, start_err = 0, hold_err = 0, ovl = 0, stalls = 0, cstart = 0;
  logic [15:0] cur = 0;
  logic csrc = 0, pv = 0, pr = 0, pbit = 0, pst = 0, pbusy = 0;
  logic [15:0] fq[$];
  logic sq[$], ack_i[$];
  int fs[$], fl[$], ack_c[$], bfall[$];
  always @(negedge clk) begin
    cyc++;
    if (reset) nb = 0;
    else begin
      if (ack0 && ack1) ovl++;
      if (ack0 || ack1) begin ack_c.push_back(cyc); ack_i.push_back(ack1); end
      if (pbusy && !busy) bfall.push_back(cyc);
      if (pv && !pr && tx_valid && (tx_bit !== pbit || tx_start !== pst)) hold_err++;
      if (tx_valid && !tx_ready) stalls++;
      if (tx_valid && tx_ready) begin
        if (tx_start !== (nb == 0)) start_err++;
        if (nb == 0) begin csrc = tx_src; cstart = cyc; end
        cur = {cur[14:0], tx_bit};
        nb++;
        if (nb == 16) begin
          fq.push_back(cur); sq.push_back(csrc); fs.push_back(cstart); fl.push_back(cyc);
          nb = 0;
        end
      end
    end
    pv = tx_valid; pr = tx_ready; pbit = tx_bit; pst = tx_start; pbusy = busy;
  end

  task automatic clear_q;
    fq.delete(); sq.delete(); fs.delete(); fl.delete();
    ack_c.delete(); ack_i.delete(); bfall.delete();
    ovl = 0; start_err = 0; hold_err = 0; stalls = 0;
  endtask

  task automatic request(input logic [1:0] m, input logic [10:0] d0, input logic [10:0] d1, output bit ok);
    int n;
    n = ack_c.size();
    @(posedge clk); #1;
    data0 = d0; data1 = d1; req0 = m[0]; req1 = m[1];
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); ok = ack_c.size() > n; end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = fq.size() >= n;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = fq.size() >= n; end
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({ack0, ack1, tx_valid, tx_start, tx_bit, busy, tx_src} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0000000", {ack0, ack1, tx_valid, tx_start, tx_bit, busy, tx_src});
    else pass_cnt++;
    total++;
    if (enc_in !== 11'h0) $display("FAIL reset_enc_in: got %h want 000", enc_in); else pass_cnt++;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_zero_frame;
    bit ok, okf;
    clear_q();
    request(2'b01, 11'h000, 11'h0, ok);
    wait_frames(1, okf);
    wait_idle();
    total++;
    if (!(ok && okf)) $display("FAIL zero_handshake: ack %0d frame %0d want 1 1", ok, okf); else pass_cnt++;
    total++;
    if (fq.size() != 1 || fq[0] !== 16'h0000) $display("FAIL zero_frame: got %h want 0000", fq.size() ? fq[0] : 16'hdead); else pass_cnt++;
    total++;
    if (sq.size() != 1 || sq[0] !== 1'b0) $display("FAIL zero_src: got %b want 0", sq.size() ? sq[0] : 1'bx); else pass_cnt++;
    total++;
    if (ack_i.size() != 1 || ack_i[0] !== 1'b0) $display("FAIL zero_ack0: acks %0d want one ack0", ack_i.size()); else pass_cnt++;
    total++;
    if (fs.size() != 1 || ack_c.size() != 1 || fs[0] - ack_c[0] != 2)
      $display("FAIL zero_latency: got %0d want 2", (fs.size() && ack_c.size()) ? fs[0] - ack_c[0] : -1);
    else pass_cnt++;
    total++;
    if (start_err != 0) $display("FAIL zero_tx_start: got %0d bad starts want 0", start_err); else pass_cnt++;
    total++;
    if (bfall.size() != 1 || fl.size() != 1 || bfall[0] - fl[0] != GAP + 1)
      $display("FAIL zero_busy_fall: got %0d want %0d", (bfall.size() && fl.size()) ? bfall[0] - fl[0] : -1, GAP + 1);
    else pass_cnt++;
  endtask

  task automatic test_ones;
    bit ok, okf;
    clear_q();
    request(2'b10, 11'h0, 11'h7FF, ok);
    wait_frames(1, okf);
    wait_idle();
    total++;
    if (!(ok && okf) || fq[0] !== 16'hFFFF) $display("FAIL ones_frame: got %h want FFFF", fq.size() ? fq[0] : 16'hdead); else pass_cnt++;
    total++;
    if (sq.size() != 1 || sq[0] !== 1'b1) $display("FAIL ones_src: got %b want 1", sq.size() ? sq[0] : 1'bx); else pass_cnt++;
  endtask

  task automatic test_one;
    bit ok, okf;
    clear_q();
    request(2'b01, 11'h001, 11'h0, ok);
    total++;
    if (enc_in !== 11'h001) $display("FAIL one_enc_in: got %h want 001", enc_in); else pass_cnt++;
    wait_frames(1, okf);
    wait_idle();
    total++;
    if (!(ok && okf) || fq[0] !== 16'h000F) $display("FAIL one_frame: got %h want 000F", fq.size() ? fq[0] : 16'hdead); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bit okf, ok;
    int bad;
    logic [3:0] seq;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    clear_q();
    data0 = 11'h001; data1 = 11'h7FF; req0 = 1; req1 = 1;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = ack_c.size() >= 4; end
    @(posedge clk); #1 req0 = 0; req1 = 0;
    wait_frames(4, okf);
    wait_idle();
    total++;
    if (!(ok && okf)) $display("FAIL b2b_progress: acks %0d frames %0d want 4 4", ack_c.size(), fq.size()); else pass_cnt++;
    seq = 4'hF;
    if (ack_i.size() >= 4) seq = {ack_i[0], ack_i[1], ack_i[2], ack_i[3]};
    total++;
    if (seq !== 4'b0101) $display("FAIL b2b_order: got %b want 0101", seq); else pass_cnt++;
    bad = 0;
    for (int i = 1; i < ack_c.size() && i < 4; i++) if (ack_c[i] - ack_c[i-1] != 19 + GAP) bad++;
    total++;
    if (bad != 0) $display("FAIL b2b_period: got %0d bad gaps want 0 (period %0d)", bad, 19 + GAP); else pass_cnt++;
    total++;
    if (ovl != 0) $display("FAIL b2b_ack_overlap: got %0d want 0", ovl); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < fq.size() && i < 4; i++)
      if (fq[i] !== ((i % 2) ? 16'hFFFF : 16'h000F) || sq[i] !== 1'(i % 2)) bad++;
    total++;
    if (bad != 0) $display("FAIL b2b_frames: got %0d bad frames want 0", bad); else pass_cnt++;
  endtask

  task automatic test_stall;
    logic [10:0] d;
    logic [3:0] pat;
    int j, n;
    bit done;
    d = 11'($urandom);
    pat = 4'b1001;
    j = 0;
    clear_q();
    @(posedge clk); #1 data1 = d; req1 = 1;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (ack_c.size() > 0) req1 = 0;
      if (tx_valid) begin tx_ready = pat[j % 4]; j++; end
      done = fq.size() >= 1;
    end
    tx_ready = 1;
    req1 = 0;
    wait_idle();
    n = nb;
    total++;
    if (!done || fq[0] !== exp_frame(d)) $display("FAIL stall_frame: got %h want %h", fq.size() ? fq[0] : 16'hdead, exp_frame(d)); else pass_cnt++;
    total++;
    if (stalls == 0 || hold_err != 0) $display("FAIL stall_hold: stalls %0d hold errors %0d want >0 and 0", stalls, hold_err); else pass_cnt++;
    total++;
    if (start_err != 0 || n != 0 || fq.size() != 1) $display("FAIL stall_count: start errs %0d leftover %0d frames %0d want 0 0 1", start_err, n, fq.size()); else pass_cnt++;
  endtask

  task automatic test_enc_ready;
    logic [10:0] d;
    bit ok, okf;
    int v, rc;
    d = 11'($urandom);
    clear_q();
    enc_ready = 0;
    request(2'b01, d, 11'h0, ok);
    v = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (tx_valid) v++; end
    @(posedge clk); #1 enc_ready = 1;
    rc = cyc;
    wait_frames(1, okf);
    wait_idle();
    total++;
    if (v != 0) $display("FAIL encrdy_early_valid: got %0d want 0", v); else pass_cnt++;
    total++;
    if (!(ok && okf) || fq[0] !== exp_frame(d)) $display("FAIL encrdy_frame: got %h want %h", fq.size() ? fq[0] : 16'hdead, exp_frame(d)); else pass_cnt++;
    total++;
    if (fs.size() != 1 || fs[0] - rc != 2) $display("FAIL encrdy_latency: got %0d want 2", fs.size() ? fs[0] - rc : -1); else pass_cnt++;
  endtask

  task automatic test_midreset;
    bit ok, hit;
    int bad;
    clear_q();
    request(2'b10, 11'($urandom), 11'($urandom), ok);
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin @(negedge clk); hit = nb >= 9; end
    @(posedge clk); #1 reset = 1;
    #1;
    total++;
    if (!(ok && hit) || tx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_async: reached %0d valid %b busy %b want 1 0 0", hit, tx_valid, busy);
    else pass_cnt++;
    @(posedge clk); #1 reset = 0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin @(negedge clk); if (tx_valid || ack0 || ack1 || busy) bad++; end
    total++;
    if (bad != 0 || fq.size() != 0 || nb != 0) $display("FAIL midreset_residue: got %0d events %0d frames want 0 0", bad, fq.size()); else pass_cnt++;
  endtask

  task automatic test_random;
    logic model_last;
    logic [1:0] m;
    logic [10:0] d0, d1;
    logic g;
    bit ok, okf;
    model_last = 1;
    for (int it = 0; it < 8; it++) begin
      m = 2'($urandom_range(1, 3));
      d0 = 11'($urandom);
      d1 = 11'($urandom);
      g = (m == 2'b11) ? !model_last : m[1];
      model_last = g;
      clear_q();
      request(m, d0, d1, ok);
      wait_frames(1, okf);
      wait_idle();
      total++;
      if (!(ok && okf) || fq[0] !== exp_frame(g ? d1 : d0) || sq[0] !== g)
        $display("FAIL random_%0d: got %h src %b want %h src %b", it, fq.size() ? fq[0] : 16'hdead, sq.size() ? sq[0] : 1'bx, exp_frame(g ? d1 : d0), g);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_ones();
    test_one();
    test_back_to_back();
    test_stall();
    test_enc_ready();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
